// File: rtl/uart_rx_framer.sv
// uart_rx_framer
//   Receives 8N1 UART frames (LSB first) from an asynchronous line and
//   hands each byte to a downstream stage through a valid/ready handshake.
//
// Parameters
//   CLKS_PER_BIT  hw_clk cycles per UART bit (4..65535)
//   SYNC_STAGES   flops in the uartrx synchronizer (2..3)
//
// Ports
//   hw_clk        single clock, rising edge
//   reset         asynchronous, active-high reset
//   uartrx        serial line, idle high
//   rx_data       received byte, valid while rx_valid=1
//   rx_valid      byte available downstream
//   rx_ready      downstream accepts on rx_valid & rx_ready
//   rx_frame_err  one-cycle pulse when the stop bit is sampled low
//   rx_overrun    sticky: a completed byte was dropped (cleared by reset)
//   rx_busy       receiver is not idle
module uart_rx_framer #(
  parameter int CLKS_PER_BIT = 417,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       hw_clk,
  input  logic       reset,
  input  logic       uartrx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_frame_err,
  output logic       rx_overrun,
  output logic       rx_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  // Half a bit period lands the first sample in the middle of the start bit.
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       data_q;
  logic             valid_q;
  logic             frame_err_q;
  logic             overrun_q;

  // Synchronizer resets to the idle level so reset never looks like a start bit.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, regardless of statement order.
  always_ff @(posedge hw_clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], uartrx};
    end
  end

  assign rxs = sync_q[SYNC_STAGES-1];

  // Receive FSM with its registered outputs.
  always_ff @(posedge hw_clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      // NOTE: the shift register is reset too; it is a handful of flops, and a
      // defined value keeps simulation free of X after reset.
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;

      // Acceptance clears valid; a byte delivered on this same edge (STOP
      // branch below) overrides it.
      if (valid_q && rx_ready) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (!rxs) begin
            state_q <= START;
            cnt_q   <= HALF_LOAD;
          end
        end

        START: begin
          if (cnt_q == '0) begin
            if (rxs) begin
              state_q <= IDLE;           // glitch, not a start bit
            end else begin
              state_q <= DATA;
              cnt_q   <= BIT_LOAD;
              idx_q   <= '0;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        DATA: begin
          if (cnt_q == '0) begin
            shift_q[idx_q] <= rxs;
            cnt_q          <= BIT_LOAD;
            idx_q          <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              state_q <= STOP;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        STOP: begin
          if (cnt_q == '0) begin
            if (rxs) begin
              state_q <= IDLE;
              if (!valid_q || rx_ready) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;       // old byte still pending: drop new one
              end
            end else begin
              state_q     <= WAIT_IDLE;
              frame_err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        WAIT_IDLE: begin
          // A held-low line (break) must not restart framing until it idles.
          if (rxs) begin
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = frame_err_q;
  assign rx_overrun   = overrun_q;
  assign rx_busy      = (state_q != IDLE);

endmodule

// File: doc/uart_rx_framer.md
UART_RX_FRAMER -- requirements
Module: uart_rx_framer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 417, meaning hw_clk cycles per UART bit (48 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning the number of flops in the uartrx synchronizer; legal range 2..3.
REQ-003 SHALL have port hw_clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port uartrx, input, 1 bit: asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 SHALL have port rx_data, output, 8 bits: received byte, valid while rx_valid=1.
REQ-007 SHALL have port rx_valid, output, 1 bit: byte available to the downstream NAND command stage.
REQ-008 SHALL have port rx_ready, input, 1 bit: downstream accepts rx_data on a cycle where rx_valid=1 and rx_ready=1.
REQ-009 SHALL have port rx_frame_err, output, 1 bit: one-cycle pulse when the stop bit is sampled low.
REQ-010 SHALL have port rx_overrun, output, 1 bit: sticky flag, set when a completed byte is dropped; cleared only by reset.
REQ-011 SHALL have port rx_busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-012 SHALL pass uartrx through a SYNC_STAGES flop synchronizer whose flops reset to 1; all FSM logic SHALL use only the synchronized signal rxs.
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP and WAIT_IDLE, driven by a bit-period counter (clog2(CLKS_PER_BIT) bits) and a 3-bit bit index.
REQ-014 IDLE: when rxs=0, the FSM SHALL go to START and load the counter with CLKS_PER_BIT/2 (integer floor) - 1.
REQ-015 START: when the counter reaches 0, the FSM SHALL sample rxs; rxs=1 is a false start and returns to IDLE with no flags; rxs=0 goes to DATA with the counter = CLKS_PER_BIT-1 and index = 0.
REQ-016 DATA: when the counter reaches 0, the FSM SHALL shift rxs into shift-register bit [index], reload the counter, and increment the index; after index 7 it SHALL go to STOP.
REQ-017 STOP: when the counter reaches 0, rxs=1 SHALL deliver the byte (REQ-019) and go to IDLE; rxs=0 SHALL pulse rx_frame_err for 1 cycle, discard the byte, and go to WAIT_IDLE.
REQ-018 WAIT_IDLE: the FSM SHALL stay until rxs=1, then go to IDLE; this prevents a break condition from generating repeated frames.
REQ-019 Delivery: on the stop-sample edge, if the output is free (rx_valid=0, or rx_valid&rx_ready in that same cycle), the block SHALL load rx_data and hold rx_valid=1; otherwise it SHALL keep the old rx_data and rx_valid, and set rx_overrun.
REQ-020 Latency: rx_valid SHALL rise on the clock edge of the mid-stop-bit sample, 9.5 bit periods + SYNC_STAGES cycles (±1) after the uartrx falling edge.
REQ-021 Handshake: rx_valid SHALL remain 1 with rx_data stable until accepted; acceptance SHALL clear rx_valid on the next edge unless a new byte loads on that same edge.
REQ-022 rx_ready SHALL have no effect while rx_valid=0; it SHALL never influence reception timing.
REQ-023 The counter SHALL never wrap or underflow; every reload happens exactly at zero.

Reset
REQ-024 Asserting reset at any time, including mid-frame, SHALL immediately force: FSM=IDLE, counter=0, index=0, synchronizer=all 1, rx_data=8'h00, rx_valid=0, rx_frame_err=0, rx_overrun=0, rx_busy=0.
REQ-025 After reset deasserts while uartrx=0, the FSM SHALL treat the line as a start bit and begin a frame; no frame SHALL be reported until a valid stop bit.

Verification (CLKS_PER_BIT=8 unless noted)
REQ-026 The bench SHALL cover: send 0xA5 with rx_ready=1 -> one rx_valid pulse with rx_data=0xA5; no error flags.
REQ-027 The bench SHALL cover: send 0x3C then 0x81 with rx_ready=0 -> rx_data holds 0x3C; rx_overrun=1 after the second stop bit; raising rx_ready delivers 0x3C only.
REQ-028 The bench SHALL cover: send 0x55 with the stop bit forced low for 3 bit periods -> one rx_frame_err pulse; rx_valid stays 0; the next frame 0x12 is received correctly.
REQ-029 The bench SHALL cover: a 2-cycle low glitch on idle uartrx -> return to IDLE from START; rx_valid=0; no flags.
REQ-030 The bench SHALL cover: reset pulsed during DATA bit 4 -> all outputs at reset values; a following 0xF0 is received correctly.
REQ-031 The bench SHALL cover: CLKS_PER_BIT=417 with a 48 MHz hw_clk, sending 0x00 and 0xFF with ±2% baud skew -> both bytes received correctly.
